// File: rtl/commit_trace_queue_pkg.sv
// Shared types for the commit-trace path: architectural scalar types and the
// queued trace entry record.
package commit_trace_queue_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regid_t;

    localparam regid_t R0 = 5'd0;

    // One committed instruction as it sits in the trace queue.
    typedef struct packed {
        addr_t  pc;
        logic   wen;
        regid_t wnum;
        word_t  data;
    } trace_entry_t;

endpackage

// File: rtl/commit_trace_queue_lane_pack.sv
// commit_lane_pack: combinational prefix-sum compactor. Every accepted lane gets
// an offset equal to the number of accepted lanes below it, so accepted lanes
// land contiguously in lane order. Also reports the total accepted count.
module commit_lane_pack
    import commit_trace_queue_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]    lane_ok,
    input  logic [LANES*32-1:0] lane_pc,
    output logic [LANES-1:0]    accept,
    output logic [LANES*CW-1:0] offset,
    output logic [CW-1:0]       accept_cnt
);

    logic [CW-1:0] run;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_accept
            // A lane with PC zero is a bubble and never enters the queue.
            assign accept[gi] = lane_ok[gi] && (lane_pc[gi*32 +: 32] != '0);
        end
    endgenerate

    // Running count of accepted lanes below each lane gives that lane's slot offset.
    always_comb begin
        run    = '0;
        offset = '0;
        for (int i = 0; i < LANES; i++) begin
            offset[i*CW +: CW] = run;
            run = run + CW'(accept[i]);
        end
        accept_cnt = run;
    end

endmodule

// File: rtl/commit_trace_queue.sv
// commit_trace_queue: packs up to LANES commits per cycle into a DEPTH-entry
// circular queue and drains one entry per cycle onto the debug_wb_* ports.
// Optional build macro COMMIT_TRACE_SKIP_NOWB_EN: when defined, commits that do
// not write a register are not traced at all.
module commit_trace_queue
    import commit_trace_queue_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       commit_en,
    input  logic [LANES*32-1:0]    commit_pc,
    input  logic [LANES-1:0]       commit_wen,
    input  logic [LANES*5-1:0]     commit_wnum,
    input  logic [LANES*32-1:0]    commit_data,
    output logic [31:0]            debug_wb_pc,
    output logic [3:0]             debug_wb_rf_wen,
    output logic [4:0]             debug_wb_rf_wnum,
    output logic [31:0]            debug_wb_rf_wdata,
    output logic                   trace_stall,
    output logic                   trace_overflow,
    output logic [$clog2(DEPTH):0] trace_count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(LANES + 1);

    trace_entry_t mem [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            stall_q, stall_d;
    logic            overflow_q, overflow_d;
    trace_entry_t    out_q, out_d;

    logic [LANES-1:0]    lane_keep;
    logic [LANES-1:0]    lane_accept;
    logic [LANES*CW-1:0] lane_off;
    logic [CW-1:0]       accept_cnt;
    logic [LANES-1:0]    lane_store;
    logic [PW-1:0]       lane_idx [LANES];
    trace_entry_t        lane_entry [LANES];

    logic            popped;
    logic [CNTW-1:0] free_slots;
    logic [CNTW-1:0] accept_ext;
    logic [CNTW-1:0] stored_cnt;

`ifdef COMMIT_TRACE_SKIP_NOWB_EN
    assign lane_keep = commit_en & commit_wen;
`else
    assign lane_keep = commit_en;
`endif

    commit_lane_pack #(
        .LANES (LANES),
        .CW    (CW)
    ) u_pack (
        .lane_ok    (lane_keep),
        .lane_pc    (commit_pc),
        .accept     (lane_accept),
        .offset     (lane_off),
        .accept_cnt (accept_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_entry[gi] = '{
                pc:   commit_pc[gi*32 +: 32],
                wen:  commit_wen[gi],
                wnum: commit_wnum[gi*5 +: 5],
                data: commit_data[gi*32 +: 32]
            };
            assign lane_idx[gi] = tail_q + PW'(lane_off[gi*CW +: CW]);
            // Only the first free_slots accepted lanes fit; later ones are dropped.
            assign lane_store[gi] = lane_accept[gi] &&
                                    (CNTW'(lane_off[gi*CW +: CW]) < free_slots);
        end
    endgenerate

    // Queue bookkeeping: pop, capacity after pop, push count, stall and overflow.
    always_comb begin
        popped     = (count_q != '0);
        free_slots = CNTW'(DEPTH) - count_q + CNTW'(popped);
        accept_ext = CNTW'(accept_cnt);
        stored_cnt = (accept_ext > free_slots) ? free_slots : accept_ext;
        count_d    = count_q + stored_cnt - CNTW'(popped);
        head_d     = head_q + PW'(popped);
        tail_d     = tail_q + stored_cnt[PW-1:0];
        overflow_d = overflow_q | (accept_ext > free_slots);
        stall_d    = (CNTW'(DEPTH) - count_d) < CNTW'(2 * LANES);
        if (popped) begin
            out_d = mem[head_q];
        end else begin
            out_d = '{pc: '0, wen: 1'b0, wnum: R0, data: '0};
        end
    end

    // State and output registers; reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            out_q      <= '{pc: '0, wen: 1'b0, wnum: R0, data: '0};
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
        end
    end

    // Entry storage is not reset; commits in a reset cycle are not written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_store[i]) begin
                    mem[lane_idx[i]] <= lane_entry[i];
                end
            end
        end
    end

    assign debug_wb_pc       = out_q.pc;
    assign debug_wb_rf_wen   = {4{out_q.wen}};
    assign debug_wb_rf_wnum  = out_q.wnum;
    assign debug_wb_rf_wdata = out_q.data;
    assign trace_stall       = stall_q;
    assign trace_overflow    = overflow_q;
    assign trace_count       = count_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Scoreboard bench for commit_trace_queue (LANES=2, DEPTH=8).
module tb_commit_trace_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [LANES-1:0]     commit_en;
    logic [LANES*32-1:0]  commit_pc;
    logic [LANES-1:0]     commit_wen;
    logic [LANES*5-1:0]   commit_wnum;
    logic [LANES*32-1:0]  commit_data;
    logic [31:0]          debug_wb_pc;
    logic [3:0]           debug_wb_rf_wen;
    logic [4:0]           debug_wb_rf_wnum;
    logic [31:0]          debug_wb_rf_wdata;
    logic                 trace_stall;
    logic                 trace_overflow;
    logic [3:0]           trace_count;

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic mon_on = 1'b0;

    commit_trace_queue #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .commit_en         (commit_en),
        .commit_pc         (commit_pc),
        .commit_wen        (commit_wen),
        .commit_wnum       (commit_wnum),
        .commit_data       (commit_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_stall       (trace_stall),
        .trace_overflow    (trace_overflow),
        .trace_count       (trace_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end else begin
            $display("ok   %s value=%h t=%0t", name, act, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic en, input logic [31:0] pc,
                            input logic wen, input logic [4:0] wn, input logic [31:0] d);
        commit_en[l]           = en;
        commit_pc[l*32 +: 32]  = pc;
        commit_wen[l]          = wen;
        commit_wnum[l*5 +: 5]  = wn;
        commit_data[l*32 +: 32] = d;
    endtask

    task automatic clear_lanes();
        commit_en   = '0;
        commit_pc   = '0;
        commit_wen  = '0;
        commit_wnum = '0;
        commit_data = '0;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic wen,
                            input logic [4:0] wn, input logic [31:0] d);
        exp_t e;
        e.pc = pc; e.wen = wen; e.wnum = wn; e.data = d;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (trace_count == 0 && sb.size() == 0 && debug_wb_pc == 0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain_timeout actual=count%0d/pending%0d required=empty",
                     name, trace_count, sb.size());
        end else begin
            $display("ok   %s drained", name);
        end
    endtask

    // Monitor: every non-idle output cycle pops the oldest expected entry.
    always @(negedge clk) begin
        if (mon_on) begin
            if (debug_wb_pc != 32'd0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_drain actual=%h required=none", debug_wb_pc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("drain_pc", debug_wb_pc, mon_e.pc);
                    chk("drain_rf_wen", {28'd0, debug_wb_rf_wen}, mon_e.wen ? 32'hF : 32'h0);
                    chk("drain_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, mon_e.wnum});
                    chk("drain_wdata", debug_wb_rf_wdata, mon_e.data);
                end
            end else begin
                chk("idle_fields_zero",
                    debug_wb_rf_wdata | {27'd0, debug_wb_rf_wnum} | {28'd0, debug_wb_rf_wen}, 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Hand-computed occupancy/stall for sustained dual commits into an empty DEPTH=8 queue.
    int exp_cnt   [8] = '{2, 3, 4, 5, 6, 7, 8, 8};
    int exp_stall [8] = '{0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        reset = 1'b1;
        clear_lanes();
        step();
        chk("reset_pc", debug_wb_pc, 32'd0);
        chk("reset_count", {28'd0, trace_count}, 32'd0);
        chk("reset_stall", {31'd0, trace_stall}, 32'd0);
        chk("reset_overflow", {31'd0, trace_overflow}, 32'd0);
        step();
        reset = 1'b0;
        mon_on = 1'b1;

        // Two-lane commit into empty queue: visible at t+2 and t+3.
        set_lane(0, 1, 32'h1000, 1, 5'd3, 32'hAA);
        set_lane(1, 1, 32'h1004, 1, 5'd4, 32'hBB);
        push_exp(32'h1000, 1, 5'd3, 32'hAA);
        push_exp(32'h1004, 1, 5'd4, 32'hBB);
        step();
        clear_lanes();
        chk("t1_count_after_push", {28'd0, trace_count}, 32'd2);
        chk("t1_pc_cycle1", debug_wb_pc, 32'd0);
        step();
        chk("t1_pc_cycle2", debug_wb_pc, 32'h1000);
        step();
        chk("t1_pc_cycle3", debug_wb_pc, 32'h1004);
        step();
        chk("t1_pc_cycle4", debug_wb_pc, 32'd0);
        drain("t1");

        // Lane 0 enabled with PC zero is a bubble; only lane 1 is queued.
        set_lane(0, 1, 32'h0, 1, 5'd7, 32'h77);
        set_lane(1, 1, 32'h2000, 1, 5'd8, 32'h88);
        push_exp(32'h2000, 1, 5'd8, 32'h88);
        step();
        clear_lanes();
        chk("t2_count_peak", {28'd0, trace_count}, 32'd1);
        step();
        chk("t2_count_after", {28'd0, trace_count}, 32'd0);
        drain("t2");

        // Lane 1 disabled: one entry, tail advances by one.
        set_lane(0, 1, 32'h1fc0, 0, 5'd9, 32'h99);
        push_exp(32'h1fc0, 0, 5'd9, 32'h99);
        step();
        clear_lanes();
        chk("t2b_count", {28'd0, trace_count}, 32'd1);
        drain("t2b");

        // Non-writing commit: traced only when the filter macro is off.
        set_lane(0, 1, 32'h2ffc, 0, 5'd5, 32'h11);
        set_lane(1, 1, 32'h3000, 1, 5'd6, 32'h22);
`ifndef COMMIT_TRACE_SKIP_NOWB_EN
        push_exp(32'h2ffc, 0, 5'd5, 32'h11);
`endif
        push_exp(32'h3000, 1, 5'd6, 32'h22);
        step();
        clear_lanes();
        drain("filter");

        // Sustained dual commits on DEPTH=8: stall, then overflow drops cycle-7 lane 1.
        for (int k = 0; k < 8; k++) begin
            set_lane(0, 1, 32'h4000 + 32'(8 * k), 1, 5'(k), 32'h100 + 32'(k));
            set_lane(1, 1, 32'h4004 + 32'(8 * k), 1, 5'(k + 10), 32'h200 + 32'(k));
            push_exp(32'h4000 + 32'(8 * k), 1, 5'(k), 32'h100 + 32'(k));
            if (k != 7) push_exp(32'h4004 + 32'(8 * k), 1, 5'(k + 10), 32'h200 + 32'(k));
            step();
            chk($sformatf("ovf_count_k%0d", k), {28'd0, trace_count}, 32'(exp_cnt[k]));
            chk($sformatf("ovf_stall_k%0d", k), {31'd0, trace_stall}, 32'(exp_stall[k]));
            chk($sformatf("ovf_flag_k%0d", k), {31'd0, trace_overflow}, (k == 7) ? 32'd1 : 32'd0);
        end
        clear_lanes();
        drain("ovf");
        chk("ovf_sticky", {31'd0, trace_overflow}, 32'd1);

        // Reset with 5 entries queued; commits during reset must vanish.
        for (int k = 0; k < 4; k++) begin
            set_lane(0, 1, 32'h5000 + 32'(8 * k), 1, 5'(k + 1), 32'h300 + 32'(k));
            set_lane(1, 1, 32'h5004 + 32'(8 * k), 0, 5'(k + 2), 32'h400 + 32'(k));
            push_exp(32'h5000 + 32'(8 * k), 1, 5'(k + 1), 32'h300 + 32'(k));
            push_exp(32'h5004 + 32'(8 * k), 0, 5'(k + 2), 32'h400 + 32'(k));
            step();
        end
        chk("rst_count_before", {28'd0, trace_count}, 32'd5);
        reset = 1'b1;
        set_lane(0, 1, 32'h6000, 1, 5'd1, 32'hDEAD);
        set_lane(1, 1, 32'h6004, 1, 5'd2, 32'hBEEF);
        step();
        reset = 1'b0;
        clear_lanes();
        chk("rst_discarded_pending", 32'(sb.size()), 32'd5);
        sb.delete();
        chk("rst_pc", debug_wb_pc, 32'd0);
        chk("rst_count", {28'd0, trace_count}, 32'd0);
        chk("rst_overflow", {31'd0, trace_overflow}, 32'd0);
        chk("rst_stall", {31'd0, trace_stall}, 32'd0);
        drain("rst");

        // Long single-lane stream with bubbles: pointers wrap many times.
        for (int i = 0; i < 320; i++) begin
            clear_lanes();
            set_lane(i % 2, 1, 32'h10000 + 32'(4 * i), 1'(i % 2), 5'(i % 32), 32'(i * 3 + 1));
            if (i % 3 == 0) set_lane((i + 1) % 2, 1, 32'h0, 1, 5'd31, 32'hFFFF);
            push_exp(32'h10000 + 32'(4 * i), 1'(i % 2), 5'(i % 32), 32'(i * 3 + 1));
            step();
        end
        clear_lanes();
        chk("wrap_overflow_clear", {31'd0, trace_overflow}, 32'd0);
        drain("wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
